// File: rtl/expr_pkg.sv
// Shared constants and types for the ASCII arithmetic-expression generator.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  typedef enum logic {
    OP_PLUS = 1'b0,
    OP_MUL  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIG  = 2'd1,
    S_OP   = 2'd2
  } state_e;

  function automatic logic [7:0] op_char(input logic op_bit);
    logic [7:0] ch;
    case (op_e'(op_bit))
      OP_PLUS: ch = CH_PLUS;
      OP_MUL:  ch = CH_MUL;
      default: ch = CH_PLUS;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/expr_char_enc.sv
// Combinational map from (is_op, digit, op bit) to one ASCII character.
module expr_char_enc (
  input  logic       is_op,
  input  logic [3:0] digit,
  input  logic       op_bit,
  output logic [7:0] ch
);
  import expr_pkg::*;

  // Operator slots use the op encoding, digit slots offset from ASCII '0'.
  always_comb begin
    ch = 8'h00;
    if (is_op) begin
      ch = op_char(op_bit);
    end else begin
      ch = CH_ZERO + {4'h0, digit};
    end
  end

endmodule

// File: rtl/expr_gen.sv
// Emits a latched digit/operator list as an ASCII expression stream, one char per beat.
// Optional EXPR_GEN_TRAIL_EN appends a trailing operator for malformed-stream testing.
module expr_gen #(
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic                   ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_char,
  output logic                   out_last,
  output logic                   err
);
  import expr_pkg::*;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       k_q, k_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;
  logic                   ready_q, ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_char_q, out_char_d;
  logic                   out_last_q, out_last_d;
  logic                   err_q, err_d;

  logic                   load_bad_s;
  logic                   beat_s;
  logic [3:0]             cur_digit_s;
  logic                   cur_op_s;
  logic [7:0]             enc_char_s;

  assign beat_s = out_valid_q && out_ready;

  // Load validation: count range, then BCD check on the first N terms only.
  always_comb begin
    load_bad_s = 1'b0;
    if ((num_terms == {CNT_W{1'b0}}) || (num_terms > CNT_W'(MAX_TERMS))) begin
      load_bad_s = 1'b1;
    end else begin
      for (int i = 0; i < MAX_TERMS; i++) begin
        if ((CNT_W'(i) < num_terms) && (digits[4*i +: 4] > 4'd9)) begin
          load_bad_s = 1'b1;
        end else begin
          load_bad_s = load_bad_s;
        end
      end
    end
  end

  // Next-state, index and latch update.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && load_bad_s) begin
          err_d = 1'b1;
        end else if (start) begin
          digits_d = digits;
          ops_d    = ops;
          n_d      = num_terms;
          k_d      = {CNT_W{1'b0}};
          state_d  = S_DIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIG: begin
        if (beat_s && (k_q == n_q - CNT_W'(1))) begin
`ifdef EXPR_GEN_TRAIL_EN
          state_d = S_OP;
`else
          state_d = S_IDLE;
`endif
        end else if (beat_s) begin
          state_d = S_OP;
        end else begin
          state_d = S_DIG;
        end
      end
      S_OP: begin
        if (beat_s) begin
`ifdef EXPR_GEN_TRAIL_EN
          if (k_q == n_q - CNT_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            k_d     = k_q + CNT_W'(1);
            state_d = S_DIG;
          end
`else
          k_d     = k_q + CNT_W'(1);
          state_d = S_DIG;
`endif
        end else begin
          state_d = S_OP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand/operator selection at the next index; the slot past the op list reads as '+'.
  always_comb begin
    cur_digit_s = 4'h0;
    cur_op_s    = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (k_d == CNT_W'(i)) begin
        cur_digit_s = digits_d[4*i +: 4];
      end else begin
        cur_digit_s = cur_digit_s;
      end
    end
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      if (k_d == CNT_W'(i)) begin
        cur_op_s = ops_d[i];
      end else begin
        cur_op_s = cur_op_s;
      end
    end
  end

  expr_char_enc u_enc (
    .is_op  (state_d == S_OP),
    .digit  (cur_digit_s),
    .op_bit (cur_op_s),
    .ch     (enc_char_s)
  );

  // Outputs are registered from the next state so they change together with it.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    out_valid_d = (state_d != S_IDLE);
    out_char_d  = 8'h00;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      out_char_d = enc_char_s;
`ifdef EXPR_GEN_TRAIL_EN
      out_last_d = (state_d == S_OP) && (k_d == n_d - CNT_W'(1));
`else
      out_last_d = (state_d == S_DIG) && (k_d == n_d - CNT_W'(1));
`endif
    end else begin
      out_char_d = 8'h00;
      out_last_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      k_q         <= {CNT_W{1'b0}};
      n_q         <= {CNT_W{1'b0}};
      digits_q    <= {(4*MAX_TERMS){1'b0}};
      ops_q       <= {(MAX_TERMS-1){1'b0}};
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      digits_q    <= digits_d;
      ops_q       <= ops_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign ready     = ready_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule
